multi_shift_reg: RTL

Parametrised multi-channel serial shift register. It is the next generation of the fixed 16-bit, four-instance pin delay line. It adds configurable depth and channel count, a runtime-selectable delay tap, shift direction, rotate, parallel load and readback, and a counted burst-shift controller. The top-level instantiates it between io_in and io_out pins, one channel per pin.

---
 rtl/multi_shift_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/multi_shift_reg.sv
// rtl/multi_shift_reg.sv - multi-channel serial shift register with tap select, rotate, load and burst shift
// All channels share control; a small IDLE/RUN/DONE FSM drives counted bursts of teff+1 shifts.

module multi_shift_reg #(
  parameter  int CHANNELS = 4,
  parameter  int DEPTH    = 16,
  localparam int TAP_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      dir,
  input  logic [TAP_W-1:0]          tap,
  input  logic [CHANNELS-1:0]       sin,
  input  logic [CHANNELS*DEPTH-1:0] pload,
  output logic [CHANNELS-1:0]       sout,
  output logic [CHANNELS*DEPTH-1:0] pout,
  input  logic                      burst_start,
  output logic                      burst_busy,
  output logic                      burst_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(DEPTH - 1);

  state_e                    state_q, state_d;
  logic [TAP_W-1:0]          cnt_q, cnt_d;
  logic [TAP_W-1:0]          teff;
  logic [TAP_W-1:0]          sel_idx;
  logic [CHANNELS*DEPTH-1:0] data_q, data_d;
  logic                      do_shift;
  logic                      do_rotate;
  logic                      do_load;

  // Taps beyond the last stage saturate; the output stage is counted from the entry end.
  assign teff    = (int'(tap) > DEPTH - 1) ? MAX_TAP : tap;
  assign sel_idx = dir ? teff : (MAX_TAP - teff);
  assign pout    = data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (burst_start) begin
          state_d = S_RUN;
          cnt_d   = teff;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - TAP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    burst_busy = (state_q == S_RUN);
    burst_done = (state_q == S_DONE);
    do_shift   = 1'b0;
    do_rotate  = 1'b0;
    do_load    = 1'b0;
    if (state_q == S_RUN) begin
      do_shift = 1'b1;
    end else if (en) begin
      case (mode)
        2'b00:   do_shift = 1'b1;
        2'b01: begin
          do_shift  = 1'b1;
          do_rotate = 1'b1;
        end
        2'b10:   do_load = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DEPTH-1:0] cur;
    logic [DEPTH-1:0] shifted;
    logic             entry;

    assign cur = data_q[c*DEPTH +: DEPTH];

    // dir=0 enters at the top stage and drains at stage 0; dir=1 is the mirror.
    always_comb begin
      if (do_rotate) begin
        entry = dir ? cur[DEPTH-1] : cur[0];
      end else begin
        entry = sin[c];
      end
      if (dir) begin
        shifted = {cur[DEPTH-2:0], entry};
      end else begin
        shifted = {entry, cur[DEPTH-1:1]};
      end
    end

    assign data_d[c*DEPTH +: DEPTH] = do_load  ? pload[c*DEPTH +: DEPTH] :
                                      do_shift ? shifted : cur;
    assign sout[c] = cur[sel_idx];
  end

endmodule
